multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the LEGv8 subset datapath: AND/ORR/ADD/SUB (reg), ADDI/SUBI, MOVZ, B, CBZ, LDUR, STUR.
//  Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB over several clocks.
//  Replaces the single-cycle decoder and drives PC, IR, register-file, ALU and memory enables.
//  Waits on a variable-latency memory via a ready handshake.
//  Halts on an illegal opcode or a memory timeout.
// PARAMETERS
//  TIMEOUT  16  max cycles to wait for mem_ready in FETCH or MEM before halting (>=1)
//  CNT_W    32  width of performance counters (PERF_CNT_EN only)
// PORTS
//  CLK            in   1   rising-edge clock
//  resetl         in   1   synchronous reset, active-low
//  opcode         in   11  IR[31:21], valid from DECODE onward
//  zero           in   1   ALU zero flag, sampled in EXEC
//  mem_ready      in   1   memory done: fetch word on rdata, load data valid, or store committed
//  pc_write       out  1   load PC this cycle
//  pc_src         out  1   0 = PC+4, 1 = branch target (from OLDPC + sign-extended imm)
//  ir_write       out  1   load IR and OLDPC from the fetch word
//  mem_iaddr      out  1   1 = memory address is the PC (fetch), 0 = ALU result
//  memread        out  1   memory read request
//  memwrite       out  1   memory write request
//  reg2loc        out  1   1 = Rm field from IR[4:0]
//  alusrc         out  1   1 = ALU B is the extended immediate
//  mem2reg        out  1   1 = writeback from memory data
//  regwrite       out  1   register-file write enable
//  aluop          out  4   0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
//  signop         out  2   00 I-type, 01 D-type, 10 B, 11 CB
//  state          out  3   current state encoding (debug)
//  illegal        out  1   sticky: halted on an undecodable opcode
//  timeout        out  1   sticky: halted on a mem_ready timeout
// BEHAVIOUR
//  Opcode match (? = don't care):
//   ANDREG ?0001010???   ORRREG ?0101010???   ADDREG ?0?01011???   SUBREG ?1?01011???
//   ADDIMM ?0?10001???   SUBIMM ?1?10001???   MOVZ 110100101??
//   B ?00101?????        CBZ ?011010????      LDUR ??111000010      STUR ??111000000
//  Priority order is as listed; the first match wins.
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
//  Reset:
//   - resetl==0 at a clock edge -> state=FETCH, op_q=0, wait counter=0, illegal=0, timeout=0.
//   - While resetl==0, every enable output is forced to 0.
//   - Reset mid-operation abandons the instruction; no further write strobes are issued.
//  FETCH:
//   - Asserts mem_iaddr=1 and memread=1.
//   - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
//   - Otherwise stay in FETCH and increment the wait counter.
//  DECODE (1 cycle): latch op_q<=opcode and classify. Undecodable -> HALT with illegal=1. Otherwise -> EXEC.
//  EXEC (1 cycle): drives aluop, alusrc, reg2loc and signop for op_q.
//   - R-type: alusrc=0, reg2loc=0.
//   - ADDI/SUBI: alusrc=1, signop=00, aluop=ADD or SUB.
//   - MOVZ: alusrc=1, aluop=0111, signop=00.
//   - LDUR/STUR: alusrc=1, signop=01, aluop=0010; STUR also reg2loc=1.
//   - CBZ: reg2loc=1, alusrc=0, aluop=0111, signop=11; if zero==1 then pc_write=1, pc_src=1.
//   - B: signop=10, pc_write=1, pc_src=1.
//   - Next state: B/CBZ -> FETCH; LDUR/STUR -> MEM; all others -> WB.
//  MEM:
//   - Holds the EXEC aluop/alusrc/signop; mem_iaddr=0; memread=1 for LDUR, memwrite=1 for STUR.
//   - Requests stay asserted until mem_ready.
//   - On mem_ready: LDUR -> WB, STUR -> FETCH.
//  WB (1 cycle): regwrite=1, mem2reg=1 for LDUR else 0, then -> FETCH.
//  Timeout:
//   - The wait counter clears on every state change.
//   - If it reaches TIMEOUT in FETCH or MEM without mem_ready -> HALT with timeout=1.
//   - mem_ready in the cycle the counter equals TIMEOUT-1 still completes normally.
//  HALT: all enables 0; stays until reset.
//  Outputs are combinational from state/op_q/zero/mem_ready and glitch-free at the edge.
//  Each instruction is exactly one cycle in DECODE, EXEC and WB.
//  Latency with 0-wait memory (mem_ready=1 in the first cycle):
//   - R/I/MOVZ 4 cycles, B/CBZ 3, STUR 4, LDUR 5.
//  memread and memwrite are never both asserted.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - Adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0], both 0 at reset.
//   - cycle_cnt increments on every non-HALT cycle.
//   - instr_cnt increments on each retiring transition (EXEC->FETCH, MEM->FETCH, WB->FETCH).
//   - Both wrap modulo 2^CNT_W.
//  PERF_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  - ADD reg (opcode 10001011000), mem_ready=1 always -> states 0,1,2,4,0; regwrite in cycle 4 only; aluop=0010.
//  - LDUR (11111000010), mem_ready delayed 3 cycles in MEM -> memread held 4 cycles, then WB with mem2reg=1; 8 cycles total.
//  - CBZ (10110100xxx): zero=1 -> pc_write=1, pc_src=1 in EXEC; zero=0 -> pc_write=0; both return to FETCH.
//  - Opcode 00000000000 -> HALT, illegal=1, no regwrite/memwrite; resetl=0 for 1 cycle -> FETCH, illegal=0.
//  - TIMEOUT=16, mem_ready held 0 in FETCH -> HALT after 16 cycles, timeout=1; mem_ready on cycle 16 -> normal DECODE.
//  - PERF_CNT_EN: 3 back-to-back ADDs at 0-wait -> instr_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Multi-cycle sequencer for the LEGv8 subset datapath (AND/ORR/ADD/SUB reg,
//   ADDI/SUBI, MOVZ, B, CBZ, LDUR, STUR). Steps the shared datapath through
//   FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file, ALU and
//   memory controls. Memory has variable latency and answers with i_mem_ready.
//   The sequencer halts on an undecodable opcode or on a memory timeout.
//
// Parameters:
//   TIMEOUT  max cycles to wait for i_mem_ready in FETCH or MEM (>= 1)
//   CNT_W    width of the performance counters (only with PERF_CNT_EN)
//
// Configuration macro:
//   PERF_CNT_EN  adds o_cycle_cnt / o_instr_cnt performance counters
//
// Ports:
//   i_clk         rising-edge clock
//   i_resetl      synchronous reset, active low
//   i_opcode      IR[31:21], valid from DECODE onward
//   i_zero        ALU zero flag, used by CBZ in EXEC
//   i_mem_ready   memory completed the current fetch/load/store
//   o_pc_write    load PC this cycle
//   o_pc_src      0 = PC+4, 1 = branch target
//   o_ir_write    load IR and OLDPC from the fetch word
//   o_mem_iaddr   1 = memory address is the PC, 0 = ALU result
//   o_memread     memory read request
//   o_memwrite    memory write request
//   o_reg2loc     1 = Rm field taken from IR[4:0]
//   o_alusrc      1 = ALU B operand is the extended immediate
//   o_mem2reg     1 = writeback data comes from memory
//   o_regwrite    register-file write enable
//   o_aluop       0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
//   o_signop      00 I-type, 01 D-type, 10 B, 11 CB
//   o_state       current state encoding (debug)
//   o_illegal     sticky: halted on an undecodable opcode
//   o_timeout     sticky: halted on a memory timeout
//   o_cycle_cnt   (PERF_CNT_EN) non-HALT cycle count
//   o_instr_cnt   (PERF_CNT_EN) retired instruction count
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int TIMEOUT = 16
`ifdef PERF_CNT_EN
  ,parameter int CNT_W = 32
`endif
) (
  input  logic        i_clk,
  input  logic        i_resetl,
  input  logic [10:0] i_opcode,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_pc_src,
  output logic        o_ir_write,
  output logic        o_mem_iaddr,
  output logic        o_memread,
  output logic        o_memwrite,
  output logic        o_reg2loc,
  output logic        o_alusrc,
  output logic        o_mem2reg,
  output logic        o_regwrite,
  output logic [3:0]  o_aluop,
  output logic [1:0]  o_signop,
  output logic [2:0]  o_state,
  output logic        o_illegal,
  output logic        o_timeout
`ifdef PERF_CNT_EN
  ,output logic [CNT_W-1:0] o_cycle_cnt
  ,output logic [CNT_W-1:0] o_instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI, C_MOVZ,
    C_B, C_CBZ, C_LDUR, C_STUR, C_ILL
  } class_t;

  // The wait counter must be able to hold TIMEOUT-1; the halt decision is
  // taken in the cycle the counter sits at TIMEOUT-1 with no ready, which is
  // the same moment it would otherwise step to TIMEOUT.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [10:0]       r_opQ;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_illegal;
  logic              r_timeout;
  class_t            w_decClass;
  class_t            w_opClass;

  // Opcode classification. The patterns overlap in their don't-care bits, so
  // this is an ordered if-chain: the first matching pattern wins.
  function automatic class_t classify(input logic [10:0] op);
    if      ((op & 11'b01111111000) == 11'b00001010000) classify = C_AND;
    else if ((op & 11'b01111111000) == 11'b00101010000) classify = C_ORR;
    else if ((op & 11'b01011111000) == 11'b00001011000) classify = C_ADD;
    else if ((op & 11'b01011111000) == 11'b01001011000) classify = C_SUB;
    else if ((op & 11'b01011111000) == 11'b00010001000) classify = C_ADDI;
    else if ((op & 11'b01011111000) == 11'b01010001000) classify = C_SUBI;
    else if ((op & 11'b11111111100) == 11'b11010010100) classify = C_MOVZ;
    else if ((op & 11'b01111100000) == 11'b00010100000) classify = C_B;
    else if ((op & 11'b01111110000) == 11'b00110100000) classify = C_CBZ;
    else if ((op & 11'b00111111111) == 11'b00111000010) classify = C_LDUR;
    else if ((op & 11'b00111111111) == 11'b00111000000) classify = C_STUR;
    else                                                classify = C_ILL;
  endfunction

  assign w_decClass = classify(i_opcode);
  assign w_opClass  = classify(r_opQ);

  assign o_state   = r_state;
  assign o_illegal = r_illegal;
  assign o_timeout = r_timeout;

  // Sequencer state, latched opcode, memory wait counter and sticky halt
  // flags. The wait counter is cleared on every state change so FETCH and MEM
  // each get a fresh TIMEOUT budget.
  always_ff @(posedge i_clk) begin
    if (!i_resetl) begin
      r_state   <= S_FETCH;
      r_opQ     <= '0;
      r_waitCnt <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_mem_ready) begin
            r_state   <= S_DECODE;
            r_waitCnt <= '0;
          end else if (r_waitCnt == WAIT_LAST) begin
            r_state   <= S_HALT;
            r_timeout <= 1'b1;
            r_waitCnt <= '0;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        S_DECODE: begin
          r_opQ     <= i_opcode;
          r_waitCnt <= '0;
          if (w_decClass == C_ILL) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_waitCnt <= '0;
          case (w_opClass)
            C_B, C_CBZ:     r_state <= S_FETCH;
            C_LDUR, C_STUR: r_state <= S_MEM;
            default:        r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (i_mem_ready) begin
            r_state   <= (w_opClass == C_LDUR) ? S_WB : S_FETCH;
            r_waitCnt <= '0;
          end else if (r_waitCnt == WAIT_LAST) begin
            r_state   <= S_HALT;
            r_timeout <= 1'b1;
            r_waitCnt <= '0;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        S_WB: begin
          r_state   <= S_FETCH;
          r_waitCnt <= '0;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state   <= S_FETCH;
          r_waitCnt <= '0;
        end
      endcase
    end
  end

  // Datapath controls are decoded combinationally from the current state,
  // the latched opcode, the zero flag and mem_ready, so the fetch/branch
  // strobes line up with the edge that completes the access. Reset overrides
  // everything so an abandoned instruction cannot strobe a write.
  always_comb begin
    o_pc_write  = 1'b0;
    o_pc_src    = 1'b0;
    o_ir_write  = 1'b0;
    o_mem_iaddr = 1'b0;
    o_memread   = 1'b0;
    o_memwrite  = 1'b0;
    o_reg2loc   = 1'b0;
    o_alusrc    = 1'b0;
    o_mem2reg   = 1'b0;
    o_regwrite  = 1'b0;
    o_aluop     = 4'b0000;
    o_signop    = 2'b00;
    case (r_state)
      S_FETCH: begin
        o_mem_iaddr = 1'b1;
        o_memread   = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        case (w_opClass)
          C_AND:  o_aluop = 4'b0000;
          C_ORR:  o_aluop = 4'b0001;
          C_ADD:  o_aluop = 4'b0010;
          C_SUB:  o_aluop = 4'b0110;
          C_ADDI: begin
            o_alusrc = 1'b1;
            o_aluop  = 4'b0010;
          end
          C_SUBI: begin
            o_alusrc = 1'b1;
            o_aluop  = 4'b0110;
          end
          C_MOVZ: begin
            o_alusrc = 1'b1;
            o_aluop  = 4'b0111;
          end
          C_LDUR: begin
            o_alusrc = 1'b1;
            o_signop = 2'b01;
            o_aluop  = 4'b0010;
          end
          C_STUR: begin
            o_alusrc  = 1'b1;
            o_signop  = 2'b01;
            o_aluop   = 4'b0010;
            o_reg2loc = 1'b1;
          end
          C_CBZ: begin
            o_reg2loc  = 1'b1;
            o_aluop    = 4'b0111;
            o_signop   = 2'b11;
            o_pc_write = i_zero;
            o_pc_src   = i_zero;
          end
          C_B: begin
            o_signop   = 2'b10;
            o_pc_write = 1'b1;
            o_pc_src   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address generation stays live while the access is outstanding.
        o_alusrc = 1'b1;
        o_signop = 2'b01;
        o_aluop  = 4'b0010;
        if (w_opClass == C_LDUR) begin
          o_memread = 1'b1;
        end else begin
          o_memwrite = 1'b1;
          o_reg2loc  = 1'b1;
        end
      end
      S_WB: begin
        o_regwrite = 1'b1;
        o_mem2reg  = (w_opClass == C_LDUR);
      end
      default: ;
    endcase
    if (!i_resetl) begin
      o_pc_write  = 1'b0;
      o_pc_src    = 1'b0;
      o_ir_write  = 1'b0;
      o_mem_iaddr = 1'b0;
      o_memread   = 1'b0;
      o_memwrite  = 1'b0;
      o_reg2loc   = 1'b0;
      o_alusrc    = 1'b0;
      o_mem2reg   = 1'b0;
      o_regwrite  = 1'b0;
      o_aluop     = 4'b0000;
      o_signop    = 2'b00;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_cycleCnt;
  logic [CNT_W-1:0] r_instrCnt;
  logic             w_retire;

  // An instruction retires on the transition back to FETCH: branches from
  // EXEC, stores from MEM on ready, everything else from WB.
  assign w_retire = ((r_state == S_EXEC) && ((w_opClass == C_B) || (w_opClass == C_CBZ)))
                 || ((r_state == S_MEM) && i_mem_ready && (w_opClass != C_LDUR))
                 || (r_state == S_WB);

  // Free-running performance counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge i_clk) begin
    if (!i_resetl) begin
      r_cycleCnt <= '0;
      r_instrCnt <= '0;
    end else begin
      if (r_state != S_HALT) begin
        r_cycleCnt <= r_cycleCnt + 1'b1;
      end
      if (w_retire) begin
        r_instrCnt <= r_instrCnt + 1'b1;
      end
    end
  end

  assign o_cycle_cnt = r_cycleCnt;
  assign o_instr_cnt = r_instrCnt;
`endif

endmodule
